// File: rtl/ibuf_pkg.sv
// Shared types for the input-buffer read-side address generator.
// Row length in words is the pixel count shifted by LINE_SHIFT.
package ibuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam int LINE_SHIFT = 3;
  localparam int LEN_W      = 9;

  typedef struct packed {
    logic sop;
    logic eol;
    logic eop;
  } rd_tag_t;

  function automatic logic [LEN_W-1:0] row_len(input logic [5:0] pic);
    row_len = LEN_W'(pic) << LINE_SHIFT;
  endfunction

endpackage

// File: rtl/gen_raddr_if.sv
// Job control, SRAM read port and output stream of the read-address generator.
// The generator uses the slave view; whatever drives jobs and serves the SRAM uses master.
interface gen_raddr_if #(
  parameter int AW = 10,
  parameter int DW = 128
);
  logic [5:0]    pic_size;
  logic          rd_start;
  logic [AW-1:0] rd_addr_start;
  logic [2:0]    rd_row_num;

  logic          sram_read_en;
  logic [AW-1:0] sram_read_addr;
  logic [DW-1:0] sram_read_data;

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eol;
  logic          out_eop;

  logic          busy;
  logic          rd_done;

  modport slave (
    input  pic_size, rd_start, rd_addr_start, rd_row_num, sram_read_data, out_ready,
    output sram_read_en, sram_read_addr, out_data, out_valid, out_sop, out_eol, out_eop,
           busy, rd_done
  );

  modport master (
    output pic_size, rd_start, rd_addr_start, rd_row_num, sram_read_data, out_ready,
    input  sram_read_en, sram_read_addr, out_data, out_valid, out_sop, out_eol, out_eop,
           busy, rd_done
  );
endinterface

// File: rtl/rd_skid_fifo.sv
// Small return buffer for SRAM read data plus markers; no bypass, data shows the cycle after push.
// Push on a full FIFO is accepted only together with a pop.
module rd_skid_fifo #(
  parameter int  W     = 131,
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     din_i,
  input  logic             pop_i,
  output logic [W-1:0]     dout_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full, push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full || pop_ok);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/gen_raddr.sv
// Read-side address generator: streams rows of SRAM words out as valid/ready with sop/eol/eop.
//   state | meaning
//   IDLE  | waiting for rd_start
//   ISSUE | issuing reads while return-buffer credit is available
//   DRAIN | all reads issued, waiting for the eop word to be handshaken
//   DONE  | rd_done pulse, back to IDLE
module gen_raddr
  import ibuf_pkg::*;
#(
  parameter int AW     = 10,
  parameter int DW     = 128,
  parameter int RD_LAT = 1
) (
  input logic        SYS_CLK,
  input logic        SYS_NRST,
  gen_raddr_if.slave bus
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rd_state_e      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, col_q, col_d;
  logic [2:0]     rows_q, rows_d, row_q, row_d;
  logic [AW-1:0]  addr_q, addr_d;

  logic           start_ok, degenerate, rd_en, last_rd, credit_ok, pop;
  rd_tag_t        rd_tag, out_tag;
  int             inflight;

  logic           vld_q [RD_LAT];
  rd_tag_t        tag_q [RD_LAT];

  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic [DW+2:0]    fifo_dout;

  assign start_ok   = (state_q == IDLE) && bus.rd_start;
  assign degenerate = (bus.pic_size == '0) || (bus.rd_row_num == '0);
  assign pop        = bus.out_ready && !fifo_empty;
  assign last_rd    = rd_en && rd_tag.eop;

  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.rd_start) state_d = degenerate ? DONE : ISSUE;
      ISSUE:   if (last_rd) state_d = DRAIN;
      DRAIN:   if (pop && out_tag.eop) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_tag.sop  = (col_q == '0) && (row_q == '0);
    rd_tag.eol  = (col_q == len_q - 1'b1);
    rd_tag.eop  = rd_tag.eol && (row_q == rows_q - 1'b1);
    rd_en       = (state_q == ISSUE) && credit_ok;
    bus.busy    = (state_q != IDLE);
    bus.rd_done = (state_q == DONE);
  end

  // A pop in this cycle frees a slot in time for data returning RD_LAT cycles later.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight += int'(vld_q[i]);
    credit_ok = (int'(fifo_cnt) + inflight) < (DEPTH + int'(pop));
  end

  always_comb begin
    len_d  = len_q;
    rows_d = rows_q;
    addr_d = addr_q;
    col_d  = col_q;
    row_d  = row_q;
    if (start_ok) begin
      len_d  = row_len(bus.pic_size);
      rows_d = bus.rd_row_num;
      addr_d = bus.rd_addr_start;
      col_d  = '0;
      row_d  = '0;
    end else if (rd_en) begin
      addr_d = addr_q + 1'b1;
      if (rd_tag.eol) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      len_q  <= '0;
      rows_q <= '0;
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      len_q  <= len_d;
      rows_q <= rows_d;
      addr_q <= addr_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_en;
      tag_q[0] <= rd_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  rd_skid_fifo #(
    .W     (DW + 3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (SYS_CLK),
    .rst_n   (SYS_NRST),
    .push_i  (vld_q[RD_LAT-1]),
    .din_i   ({tag_q[RD_LAT-1], bus.sram_read_data}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign out_tag            = rd_tag_t'(fifo_dout[DW+2:DW]);
  assign bus.out_data       = fifo_dout[DW-1:0];
  assign bus.out_valid      = !fifo_empty;
  assign bus.out_sop        = out_tag.sop;
  assign bus.out_eol        = out_tag.eol;
  assign bus.out_eop        = out_tag.eop;
  assign bus.sram_read_en   = rd_en;
  assign bus.sram_read_addr = addr_q;

endmodule
